// File: rtl/bip_multicycle_control_if.sv
// Bus between program memory / datapath and the BIP multi-cycle control unit.
// The control unit attaches through the slave modport; the driver of run/opcode uses master.
interface bip_multicycle_control_if #(
    parameter int unsigned OPCODE_LENGTH = 5,
    parameter int unsigned COUNT_WIDTH   = 16
);
    logic                     i_enable;
    logic [OPCODE_LENGTH-1:0] i_opcode;
    logic                     o_wrPC;
    logic                     o_wrACC;
    logic [1:0]               o_selA;
    logic                     o_selB;
    logic [OPCODE_LENGTH-1:0] o_opcode;
    logic                     o_wrRAM;
    logic                     o_rdRAM;
    logic [2:0]               o_state;
    logic                     o_halted;
    logic                     o_illegal;
    logic [COUNT_WIDTH-1:0]   o_instr_count;

    modport master (
        output i_enable, i_opcode,
        input  o_wrPC, o_wrACC, o_selA, o_selB, o_opcode, o_wrRAM, o_rdRAM,
               o_state, o_halted, o_illegal, o_instr_count
    );

    modport slave (
        input  i_enable, i_opcode,
        output o_wrPC, o_wrACC, o_selA, o_selB, o_opcode, o_wrRAM, o_rdRAM,
               o_state, o_halted, o_illegal, o_instr_count
    );
endinterface

// File: rtl/bip_multicycle_control.sv
// Multi-cycle BIP control unit: FETCH, DECODE, optional RAM wait states, EXEC.
// Moore outputs decoded from the state and the latched opcode; saturating retired-instruction counter.
module bip_multicycle_control #(
    parameter int unsigned OPCODE_LENGTH   = 5,
    parameter int unsigned RAM_WAIT_CYCLES = 1,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input logic                     i_clock,
    input logic                     i_reset,
    bip_multicycle_control_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(7);
    localparam logic [3:0]               WAIT_LOAD = 4'(RAM_WAIT_CYCLES);

    state_t                   state_q, state_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [3:0]               wait_q, wait_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic       dec_hlt;
    logic       dec_sto;
    logic       dec_mem;
    logic       dec_wracc;
    logic [1:0] dec_sel_a;
    logic       dec_sel_b;
    logic       dec_illegal;

    // Any opcode outside the map, including any set bit above bit 4, is illegal.
    always_comb begin
        dec_hlt     = 1'b0;
        dec_sto     = 1'b0;
        dec_mem     = 1'b0;
        dec_wracc   = 1'b0;
        dec_sel_a   = 2'b00;
        dec_sel_b   = 1'b0;
        dec_illegal = 1'b0;
        case (op_q)
            OP_HLT:  dec_hlt = 1'b1;
            OP_STO:  dec_sto = 1'b1;
            OP_LD: begin
                dec_mem   = 1'b1;
                dec_wracc = 1'b1;
                dec_sel_a = 2'b00;
            end
            OP_LDI: begin
                dec_wracc = 1'b1;
                dec_sel_a = 2'b01;
            end
            OP_ADD, OP_SUB: begin
                dec_mem   = 1'b1;
                dec_wracc = 1'b1;
                dec_sel_a = 2'b10;
            end
            OP_ADDI, OP_SUBI: begin
                dec_wracc = 1'b1;
                dec_sel_a = 2'b10;
                dec_sel_b = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_enable) state_d = FETCH;
            end
            FETCH: begin
                op_d    = bus.i_opcode;
                state_d = DECODE;
            end
            DECODE: begin
                if (dec_hlt) begin
                    state_d = HALT;
                end else if (dec_mem) begin
                    state_d = MEM;
                    wait_d  = WAIT_LOAD;
                end else begin
                    state_d = EXEC;
                end
            end
            MEM: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
                state_d = bus.i_enable ? FETCH : IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_wrPC        = 1'b0;
        bus.o_wrACC       = 1'b0;
        bus.o_selA        = 2'b00;
        bus.o_selB        = 1'b0;
        bus.o_opcode      = '0;
        bus.o_wrRAM       = 1'b0;
        bus.o_rdRAM       = 1'b0;
        bus.o_halted      = 1'b0;
        bus.o_illegal     = 1'b0;
        bus.o_state       = state_q;
        bus.o_instr_count = cnt_q;
        case (state_q)
            DECODE: begin
                bus.o_selA   = dec_sel_a;
                bus.o_selB   = dec_sel_b;
                bus.o_opcode = op_q;
            end
            MEM: begin
                bus.o_selA   = dec_sel_a;
                bus.o_selB   = dec_sel_b;
                bus.o_opcode = op_q;
                bus.o_rdRAM  = 1'b1;
            end
            EXEC: begin
                bus.o_selA    = dec_sel_a;
                bus.o_selB    = dec_sel_b;
                bus.o_opcode  = op_q;
                bus.o_wrPC    = 1'b1;
                bus.o_wrACC   = dec_wracc;
                bus.o_wrRAM   = dec_sto;
                bus.o_illegal = dec_illegal;
            end
            HALT:    bus.o_halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bip_multicycle_control.sv
// Bench for bip_multicycle_control: directed instruction sequences, a per-instruction
// trace model checked every cycle, and hand-computed literal spot checks.
module tb_bip_multicycle_control;
    localparam int unsigned OL  = 5;
    localparam int unsigned RWC = 3;
    localparam int unsigned CW  = 2;
    localparam int unsigned W   = 12 + OL + CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    bip_multicycle_control_if #(.OPCODE_LENGTH(OL), .COUNT_WIDTH(CW)) bus ();

    bip_multicycle_control #(
        .OPCODE_LENGTH(OL),
        .RAM_WAIT_CYCLES(RWC),
        .COUNT_WIDTH(CW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    // Model: current state plus a queue of the states the running instruction still has to visit.
    int          m_state = 0;
    logic [OL-1:0] m_op  = '0;
    int unsigned m_cnt   = 0;
    int          m_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_q.delete();
            m_cnt   = 0;
            m_op    = '0;
        end else if (m_q.size() > 0) begin
            m_state = m_q.pop_front();
        end else begin
            case (m_state)
                0: m_state = bus.i_enable ? 1 : 0;
                1: begin
                    m_op    = bus.i_opcode;
                    m_state = 2;
                    if (int'(m_op) == 0) begin
                        m_q.push_back(5);
                    end else begin
                        if (int'(m_op) == 2 || int'(m_op) == 4 || int'(m_op) == 6)
                            repeat (RWC) m_q.push_back(3);
                        m_q.push_back(4);
                    end
                end
                4: begin
                    if (m_cnt < (32'd1 << CW) - 1) m_cnt++;
                    m_state = bus.i_enable ? 1 : 0;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [W-1:0] expect_outs(input int s, input logic [OL-1:0] op,
                                                 input int unsigned cnt, input logic r);
        int         o;
        logic [1:0] sa;
        logic       sb, wpc, wacc, wram, il;
        logic [OL-1:0] oo;
        if (r) return '0;
        o = int'(op);
        sa = 2'b00; sb = 1'b0; oo = '0;
        wpc = 1'b0; wacc = 1'b0; wram = 1'b0; il = 1'b0;
        if (s == 2 || s == 3 || s == 4) begin
            oo = op;
            if (o == 3) sa = 2'b01;
            else if (o >= 4 && o <= 7) sa = 2'b10;
            sb = (o == 5 || o == 7);
        end
        if (s == 4) begin
            wpc  = 1'b1;
            wacc = (o >= 2 && o <= 7);
            wram = (o == 1);
            il   = (o > 7);
        end
        return {3'(s), wpc, wacc, sa, sb, oo, wram, (s == 3), (s == 5), il, CW'(cnt)};
    endfunction

    logic [W-1:0] act;
    assign act = {bus.o_state, bus.o_wrPC, bus.o_wrACC, bus.o_selA, bus.o_selB, bus.o_opcode,
                  bus.o_wrRAM, bus.o_rdRAM, bus.o_halted, bus.o_illegal, bus.o_instr_count};

    always @(posedge clk) begin
        logic [W-1:0] e;
        #3;
        e = expect_outs(m_state, m_op, m_cnt, rst);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t got=%b exp=%b", $time, act, e);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.i_enable = 1'b0;
        bus.i_opcode = '0;
        rst = 1'b1;
        step(2);
        chk("rst_state", 32'(bus.o_state), 0);
        chk("rst_count", 32'(bus.o_instr_count), 0);
        chk("rst_wrPC", 32'(bus.o_wrPC), 0);
        rst = 1'b0;

        // LDI
        bus.i_enable = 1'b1; bus.i_opcode = 5'b00011;
        step(1); chk("ldi_fetch", 32'(bus.o_state), 1); bus.i_enable = 1'b0;
        step(1); chk("ldi_decode", 32'(bus.o_state), 2);
        step(1); chk("ldi_exec", 32'(bus.o_state), 4);
        chk("ldi_wrPC", 32'(bus.o_wrPC), 1);
        chk("ldi_wrACC", 32'(bus.o_wrACC), 1);
        chk("ldi_selA", 32'(bus.o_selA), 1);
        chk("ldi_rdRAM", 32'(bus.o_rdRAM), 0);
        step(1); chk("ldi_idle", 32'(bus.o_state), 0);
        chk("ldi_count", 32'(bus.o_instr_count), 1);

        // ADD with 3 RAM wait cycles; opcode noise after FETCH must be ignored
        bus.i_enable = 1'b1; bus.i_opcode = 5'b00100;
        step(1); chk("add_fetch", 32'(bus.o_state), 1); bus.i_enable = 1'b0;
        step(1); chk("add_decode", 32'(bus.o_state), 2); bus.i_opcode = 5'b00011;
        repeat (3) begin
            step(1);
            chk("add_mem_state", 32'(bus.o_state), 3);
            chk("add_rdRAM", 32'(bus.o_rdRAM), 1);
        end
        step(1); chk("add_exec", 32'(bus.o_state), 4);
        chk("add_selA", 32'(bus.o_selA), 2);
        chk("add_selB", 32'(bus.o_selB), 0);
        chk("add_opcode", 32'(bus.o_opcode), 4);
        chk("add_exec_rdRAM", 32'(bus.o_rdRAM), 0);
        step(1); chk("add_idle", 32'(bus.o_state), 0);
        chk("add_count", 32'(bus.o_instr_count), 2);

        // Illegal opcode
        bus.i_enable = 1'b1; bus.i_opcode = 5'b11111;
        step(1); bus.i_enable = 1'b0;
        step(1); chk("ill_decode", 32'(bus.o_state), 2);
        step(1); chk("ill_pulse", 32'(bus.o_illegal), 1);
        chk("ill_wrPC", 32'(bus.o_wrPC), 1);
        chk("ill_wrACC", 32'(bus.o_wrACC), 0);
        chk("ill_wrRAM", 32'(bus.o_wrRAM), 0);
        step(1); chk("ill_pulse_end", 32'(bus.o_illegal), 0);
        chk("ill_count", 32'(bus.o_instr_count), 3);

        // LD with i_enable dropped during MEM; counter already saturated at 3
        bus.i_enable = 1'b1; bus.i_opcode = 5'b00010;
        step(2); chk("ld_decode", 32'(bus.o_state), 2);
        step(1); chk("ld_mem", 32'(bus.o_state), 3); bus.i_enable = 1'b0;
        step(2); chk("ld_mem_last", 32'(bus.o_state), 3);
        step(1); chk("ld_exec", 32'(bus.o_state), 4);
        chk("ld_wrACC", 32'(bus.o_wrACC), 1);
        chk("ld_selA", 32'(bus.o_selA), 0);
        step(1); chk("ld_idle", 32'(bus.o_state), 0);
        step(3); chk("ld_idle_hold", 32'(bus.o_state), 0);
        chk("ld_count_sat", 32'(bus.o_instr_count), 3);

        // Five back-to-back LDI after reset: counter saturates, no wrap
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rst2_count", 32'(bus.o_instr_count), 0);
        bus.i_enable = 1'b1; bus.i_opcode = 5'b00011;
        step(15); chk("ldi5_exec", 32'(bus.o_state), 4);
        chk("ldi5_count_4th", 32'(bus.o_instr_count), 3);
        bus.i_enable = 1'b0;
        step(1); chk("ldi5_idle", 32'(bus.o_state), 0);
        chk("ldi5_count", 32'(bus.o_instr_count), 3);

        // Asynchronous reset in the middle of MEM
        bus.i_enable = 1'b1; bus.i_opcode = 5'b00100;
        step(1); bus.i_enable = 1'b0;
        step(2); chk("arst_pre_mem", 32'(bus.o_state), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(bus.o_state), 0);
        chk("arst_rdRAM", 32'(bus.o_rdRAM), 0);
        chk("arst_opcode", 32'(bus.o_opcode), 0);
        chk("arst_count", 32'(bus.o_instr_count), 0);
        @(negedge clk); rst = 1'b0;

        // STO then HLT; HALT ignores i_enable
        bus.i_enable = 1'b1; bus.i_opcode = 5'b00001;
        step(3); chk("sto_exec", 32'(bus.o_state), 4);
        chk("sto_wrRAM", 32'(bus.o_wrRAM), 1);
        chk("sto_wrACC", 32'(bus.o_wrACC), 0);
        bus.i_opcode = 5'b00000;
        step(1); chk("hlt_fetch", 32'(bus.o_state), 1);
        step(2); chk("hlt_state", 32'(bus.o_state), 5);
        chk("hlt_halted", 32'(bus.o_halted), 1);
        chk("hlt_wrPC", 32'(bus.o_wrPC), 0);
        for (int i = 0; i < 10; i++) begin
            bus.i_enable = ~bus.i_enable;
            bus.i_opcode = 5'(i);
            step(1);
        end
        chk("halt_hold", 32'(bus.o_state), 5);
        chk("halt_count", 32'(bus.o_instr_count), 1);

        rst = 1'b1; step(2);
        chk("final_rst_halted", 32'(bus.o_halted), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bip_multicycle_control.md
Name: bip_multicycle_control

Overview:
Multi-cycle control unit for the BIP processor. It replaces the purely combinational opcode decoder with an FSM that sequences FETCH, DECODE, optional data-memory wait states and EXECUTE. It sits between program memory, which supplies the opcode, and the datapath, which consumes PC, ACC, mux and RAM strobes. Opcode width, data-RAM read latency and instruction-counter width are parametrised.

Parameters:
OPCODE_LENGTH, 5, opcode width in bits; the opcode map below uses the low 5 bits, and any higher bit set makes the opcode illegal.
RAM_WAIT_CYCLES, 1, data-RAM read latency in cycles; legal range 1..15.
COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
i_clock  in  1  system clock; rising edge active.
i_reset  in  1  asynchronous, active-high reset.
i_enable  in  1  run request; sampled in IDLE and at the end of EXEC.
i_opcode  in  OPCODE_LENGTH  opcode from program memory; valid during FETCH.
o_wrPC  out  1  PC increment strobe.
o_wrACC  out  1  accumulator write strobe.
o_selA  out  2  ACC source: 00 RAM, 01 immediate, 10 ALU.
o_selB  out  1  ALU operand B: 0 RAM, 1 immediate.
o_opcode  out  OPCODE_LENGTH  latched opcode forwarded to the ALU.
o_wrRAM  out  1  data-RAM write strobe.
o_rdRAM  out  1  data-RAM read strobe.
o_state  out  3  current state encoding, for debug.
o_halted  out  1  high while in HALT.
o_illegal  out  1  one-cycle pulse in EXEC when the opcode is illegal.
o_instr_count  out  COUNT_WIDTH  number of retired instructions.

Behaviour:
- Opcode map: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI. Every other value is illegal and executes as a NOP.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, EXEC=4, HALT=5.
- Reset (async, any state, including mid-instruction): state IDLE, opcode register 0, wait counter 0, o_instr_count 0. Every output reads 0.
- IDLE -> FETCH when i_enable=1; otherwise stay in IDLE.
- FETCH: opcode register <= i_opcode on the clock edge leaving FETCH. Always -> DECODE.
- DECODE, next state:
  - HLT -> HALT.
  - LD, ADD, SUB -> MEM, loading the wait counter with RAM_WAIT_CYCLES.
  - All other opcodes -> EXEC.
- MEM: o_rdRAM=1 in every MEM cycle. The counter decrements each cycle; when the counter is 1, next state is EXEC. MEM therefore lasts exactly RAM_WAIT_CYCLES cycles.
- EXEC lasts one cycle, with o_wrPC=1 and:
  - STO: o_wrRAM=1.
  - LD: o_wrACC=1, selA=00.
  - LDI: o_wrACC=1, selA=01.
  - ADD/SUB: o_wrACC=1, selA=10, selB=0.
  - ADDI/SUBI: o_wrACC=1, selA=10, selB=1.
  - Illegal: o_illegal=1, no ACC or RAM write.
  - o_instr_count increments and saturates at all-ones (no wrap).
  - Next state: FETCH if i_enable=1, else IDLE. Dropping i_enable mid-instruction never aborts the instruction.
- HALT: o_halted=1 and all strobes 0. i_enable is ignored; only i_reset exits HALT. HLT does not increment the counter and does not pulse o_wrPC.
- Output timing: Moore outputs, decoded from the state and the opcode register only.
  - o_selA, o_selB and o_opcode reflect the opcode register in DECODE, MEM and EXEC. They are 0 in IDLE, FETCH and HALT.
  - o_wrPC, o_wrACC, o_wrRAM and o_illegal are high only in EXEC.
  - o_rdRAM is high only in MEM.
- Latency: non-memory instruction 3 cycles (FETCH, DECODE, EXEC); memory-read instruction 3 + RAM_WAIT_CYCLES cycles.
- i_opcode changes outside FETCH have no effect.

Test Plan:
- Reset, then i_enable=1, opcode 00011 (LDI) -> states 1,2,4; EXEC shows wrPC=1, wrACC=1, selA=01, rdRAM=0; o_instr_count=1.
- RAM_WAIT_CYCLES=3, opcode 00100 (ADD) -> o_rdRAM high for exactly 3 cycles (state 3); EXEC shows selA=10, selB=0, o_opcode=00100; total 6 cycles.
- Sequence STO (00001) then HLT (00000) -> STO EXEC pulses wrRAM=1, wrACC=0; HLT reaches HALT with o_halted=1; toggling i_enable for 10 cycles leaves the state at 5 and o_instr_count at 1.
- Opcode 11111 -> o_illegal one-cycle pulse, wrPC=1, wrACC=0, wrRAM=0; counter increments.
- i_enable dropped during MEM of LD -> EXEC still completes with wrACC=1, then IDLE; state holds 0 until i_enable=1.
- Assert i_reset asynchronously mid-MEM -> outputs 0 and state 0 immediately, before the next clock edge. With COUNT_WIDTH=2, five LDI instructions -> o_instr_count saturates at 3.
